snake_step_scheduler: RTL and testbench

//  Paces and sequences snake movement while the game FSM reports RUNNING.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/dir_queue.sv | 66 ++++++
 rtl/snake_step_scheduler.sv | 164 ++++++++++++++++
 tb/tb_snake_step_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snake_pkg : direction/game-state encodings shared by scheduler and FSM    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [1:0] GS_RUNNING = 2'b00;
   localparam logic [1:0] GS_DIE     = 2'b01;
   localparam logic [1:0] GS_INITIAL = 2'b10;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_REQ  = 2'd2;

   function automatic logic [1:0] opposite(input logic [1:0] d);
      return {d[1], ~d[0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dir_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dir_queue : 2-entry FIFO of pending headings with flush and tail peek     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module dir_queue (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic [1:0] push_dir,
   input  logic       pop,
   output logic [1:0] head,
   output logic [1:0] tail,
   output logic [1:0] count
);

   logic [1:0] r_slot0;
   logic [1:0] r_slot1;
   logic [1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot0 <= 2'd0;
         r_slot1 <= 2'd0;
         r_count <= 2'd0;
      end else if (flush) begin
         r_count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_slot0 <= push_dir;
                  r_count <= 2'd1;
               end else if (r_count == 2'd1) begin
                  r_slot1 <= push_dir;
                  r_count <= 2'd2;
               end
            end
            2'b01: begin
               if (r_count != 2'd0) begin
                  r_slot0 <= r_slot1;
                  r_count <= r_count - 2'd1;
               end
            end
            2'b11: begin
               // Pop of an empty queue is a no-op, so the push still lands
               if (r_count == 2'd2) begin
                  r_slot0 <= r_slot1;
                  r_slot1 <= push_dir;
               end else begin
                  r_slot0 <= push_dir;
                  r_count <= 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = r_slot0;
   assign tail  = (r_count == 2'd2) ? r_slot1 : r_slot0;
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/snake_step_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snake_step_scheduler : paces snake steps, queues turns, tracks growth     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module snake_step_scheduler
   import snake_pkg::*;
#(
   parameter int BASE_PERIOD    = 25_000_000,
   parameter int PERIOD_DEC     = 2_500_000,
   parameter int MAX_LEVEL      = 7,
   parameter int FOOD_PER_LEVEL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] game_state,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       food_eaten,
   input  logic       step_ack,
   output logic       step_req,
   output logic [1:0] dir,
   output logic       grow,
   output logic [2:0] speed_level
);

   localparam int CNT_W  = $clog2(BASE_PERIOD + 1);
   localparam int FOOD_W = $clog2(FOOD_PER_LEVEL + 1);

   function automatic logic [CNT_W-1:0] period_for(input logic [2:0] lvl);
      logic [31:0] dec;
      dec = {29'd0, lvl} * 32'(PERIOD_DEC);
      if (dec >= 32'(BASE_PERIOD)) return CNT_W'(1);
      return CNT_W'(32'(BASE_PERIOD) - dec);
   endfunction

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_period;
   logic [1:0]        r_dir;
   logic              r_grow;
   logic [2:0]        r_grow_pend;
   logic [FOOD_W-1:0] r_food_cnt;
   logic [2:0]        r_level;

   logic       w_running, w_die, w_key_en;
   logic       w_key_valid;
   logic [1:0] w_key;
   logic [1:0] w_ref;
   logic       w_push, w_pop, w_step, w_ack, w_food, w_dec;
   logic [1:0] q_head, q_tail, q_count;

   assign w_running = (game_state == GS_RUNNING);
   assign w_die     = game_state[0];
   assign w_key_en  = w_running || (game_state == GS_INITIAL);

   always_comb begin
      w_key_valid = up | down | left | right;
      w_key       = DIR_RIGHT;
      if (up)        w_key = DIR_UP;
      else if (down) w_key = DIR_DOWN;
      else if (left) w_key = DIR_LEFT;
   end

   // New keys are judged against the last heading that will actually be taken
   assign w_ref  = (q_count != 2'd0) ? q_tail : r_dir;
   assign w_push = w_key_en && w_key_valid && (w_key != w_ref) &&
                   (w_key != opposite(w_ref)) && (q_count != 2'd2);
   assign w_step = w_running && (r_state == S_WAIT) &&
                   (r_cnt == r_period - CNT_W'(1));
   assign w_pop  = w_step && (q_count != 2'd0);
   assign w_ack  = w_running && (r_state == S_REQ) && step_ack;
   assign w_food = w_running && food_eaten;
   assign w_dec  = w_ack && r_grow;

   dir_queue u_dir_queue (
      .clk      (clk),
      .rst      (rst),
      .flush    (w_die),
      .push     (w_push),
      .push_dir (w_key),
      .pop      (w_pop),
      .head     (q_head),
      .tail     (q_tail),
      .count    (q_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (!w_running) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_next_state = S_WAIT;
            S_WAIT:  if (w_step) w_next_state = S_REQ;
            S_REQ:   if (step_ack) w_next_state = S_WAIT;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      step_req    = (r_state == S_REQ);
      dir         = r_dir;
      grow        = r_grow;
      speed_level = r_level;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_period    <= CNT_W'(BASE_PERIOD);
         r_dir       <= DIR_RIGHT;
         r_grow      <= 1'b0;
         r_grow_pend <= 3'd0;
         r_food_cnt  <= '0;
         r_level     <= 3'd0;
      end else begin
         if (!w_running || r_state == S_IDLE)
            r_cnt <= '0;
         else if (r_state == S_WAIT)
            r_cnt <= w_step ? '0 : r_cnt + CNT_W'(1);

         // Period tracks the level only between steps, never mid-countdown
         if (r_state == S_IDLE || w_ack)
            r_period <= period_for(r_level);

         if (w_die)      r_dir <= DIR_RIGHT;
         else if (w_pop) r_dir <= q_head;

         if (!w_running || w_ack) r_grow <= 1'b0;
         else if (w_step)         r_grow <= (r_grow_pend != 3'd0);

         if (w_die)
            r_grow_pend <= 3'd0;
         else if (w_food && !w_dec && r_grow_pend != 3'd7)
            r_grow_pend <= r_grow_pend + 3'd1;
         else if (!w_food && w_dec)
            r_grow_pend <= r_grow_pend - 3'd1;

         if (w_die) begin
            r_food_cnt <= '0;
            r_level    <= 3'd0;
         end else if (w_food) begin
            if (r_food_cnt == FOOD_W'(FOOD_PER_LEVEL - 1)) begin
               r_food_cnt <= '0;
               if (r_level != 3'(MAX_LEVEL)) r_level <= r_level + 3'd1;
            end else begin
               r_food_cnt <= r_food_cnt + FOOD_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_snake_step_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_snake_step_scheduler : directed + random checks against a game model   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_snake_step_scheduler;

   localparam int BP  = 20;
   localparam int PD  = 4;
   localparam int ML  = 3;
   localparam int FPL = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] game_state;
   logic       up, down, left, right, food_eaten, step_ack;
   logic       step_req;
   logic [1:0] dir;
   logic       grow;
   logic [2:0] speed_level;

   snake_step_scheduler #(
      .BASE_PERIOD    (BP),
      .PERIOD_DEC     (PD),
      .MAX_LEVEL      (ML),
      .FOOD_PER_LEVEL (FPL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .game_state  (game_state),
      .up          (up),
      .down        (down),
      .left        (left),
      .right       (right),
      .food_eaten  (food_eaten),
      .step_ack    (step_ack),
      .step_req    (step_req),
      .dir         (dir),
      .grow        (grow),
      .speed_level (speed_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Game-level reference: heading, pending turns, countdown, growth, level
   bit         m_req, m_grow, m_active;
   logic [1:0] m_dir;
   logic [1:0] m_q[$];
   int         m_pend, m_food, m_level, m_period, m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_req = 0; m_grow = 0; m_active = 0; m_dir = 2'd3;
      m_q.delete();
      m_pend = 0; m_food = 0; m_level = 0; m_period = BP; m_cnt = 0;
   endtask

   task automatic model_step();
      bit running, die, keyen, kv, step, ackok, push, n_req, n_grow;
      logic [1:0] k, rf, n_dir;
      int n_pend, n_food, n_level, n_period, n_cnt;
      running = (game_state == 2'd0);
      die     = game_state[0];
      keyen   = running || (game_state == 2'd2);
      kv      = up | down | left | right;
      k       = up ? 2'd0 : down ? 2'd1 : left ? 2'd2 : 2'd3;
      rf      = (m_q.size() > 0) ? m_q[$] : m_dir;
      push    = keyen && kv && (k != rf) && (k != (rf ^ 2'd1)) && (m_q.size() < 2);
      step    = running && m_active && !m_req && (m_cnt == m_period - 1);
      ackok   = running && m_req && step_ack;

      n_period = m_period;
      if (!m_active || ackok) n_period = (BP - m_level * PD > 1) ? BP - m_level * PD : 1;
      n_cnt = m_cnt;
      if (!running || !m_active) n_cnt = 0;
      else if (!m_req)           n_cnt = step ? 0 : m_cnt + 1;

      n_dir = m_dir;
      if (die) begin
         m_q.delete();
         n_dir = 2'd3;
      end else begin
         if (step && m_q.size() > 0) n_dir = m_q.pop_front();
         if (push) m_q.push_back(k);
      end

      n_req  = running && (step || (m_req && !ackok));
      n_grow = running && !ackok && (step ? (m_pend != 0) : m_grow);

      n_pend = m_pend; n_food = m_food; n_level = m_level;
      if (die) begin
         n_pend = 0; n_food = 0; n_level = 0;
      end else begin
         if (running && food_eaten) begin
            n_pend = n_pend + 1;
            n_food = n_food + 1;
            if (n_food == FPL) begin
               n_food  = 0;
               n_level = (m_level < ML) ? m_level + 1 : ML;
            end
         end
         if (ackok && m_grow) n_pend = n_pend - 1;
         if (n_pend > 7) n_pend = 7;
      end

      m_req = n_req; m_grow = n_grow; m_dir = n_dir; m_active = running;
      m_pend = n_pend; m_food = n_food; m_level = n_level;
      m_period = n_period; m_cnt = n_cnt;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      check("step_req", 32'(step_req), 32'(m_req));
      check("dir", 32'(dir), 32'(m_dir));
      check("grow", 32'(grow), 32'(m_grow));
      check("speed_level", 32'(speed_level), 32'(m_level));
      up = 0; down = 0; left = 0; right = 0; food_eaten = 0; step_ack = 0;
   endtask

   // Acks any outstanding request one cycle after it is seen, then waits for the next one
   task automatic wait_step(output logic [1:0] d, output logic g, output int t);
      logic prev;
      bit   found;
      found = 0; d = 2'd0; g = 1'b0; t = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         prev     = step_req;
         step_ack = step_req;
         cycle();
         if (step_req && !prev) begin
            found = 1; d = dir; g = grow; t = cyc;
         end
      end
      check("step_timeout", 32'(found), 32'd1);
   endtask

   task automatic food_burst(input int n);
      for (int i = 0; i < 2 * n; i++) begin
         step_ack   = step_req;
         food_eaten = (i % 2 == 0);
         cycle();
      end
   endtask

   initial begin
      logic [1:0] d;
      logic       g;
      int         t0, t1, t2, t3;
      logic [2:0] lvl_before;

      rst = 0; game_state = 2'd2;
      up = 0; down = 0; left = 0; right = 0; food_eaten = 0; step_ack = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_step_req", 32'(step_req), 32'd0);
      check("rst_dir", 32'(dir), 32'd3);
      check("rst_grow", 32'(grow), 32'd0);
      check("rst_level", 32'(speed_level), 32'd0);
      @(negedge clk);
      rst = 1;

      // Plain pacing: one step every period+1 cycles, heading RIGHT, no growth
      game_state = 2'd0;
      t0 = cyc;
      wait_step(d, g, t1);
      check("t1_first_latency", 32'(t1 - t0), 32'd21);
      check("t1_dir", 32'(d), 32'd3);
      check("t1_grow", 32'(g), 32'd0);
      wait_step(d, g, t2);
      check("t1_interval", 32'(t2 - t1), 32'd21);
      wait_step(d, g, t3);
      check("t1_interval2", 32'(t3 - t2), 32'd21);

      // Keys pressed before the game starts set the first headings
      game_state = 2'd2; cycle();
      up = 1;   cycle();
      left = 1; cycle();
      down = 1; cycle();
      game_state = 2'd0;
      wait_step(d, g, t1);
      check("t2_first_dir", 32'(d), 32'd0);
      wait_step(d, g, t1);
      check("t2_second_dir", 32'(d), 32'd2);
      wait_step(d, g, t1);
      check("t2_third_dropped", 32'(d), 32'd2);

      // Growth and speed-up
      food_burst(4);
      check("t4_level2", 32'(speed_level), 32'd2);
      wait_step(d, g, t1);
      check("t4_grow1", 32'(g), 32'd1);
      wait_step(d, g, t2);
      check("t4_grow2", 32'(g), 32'd1);
      check("t4_period12", 32'(t2 - t1), 32'd13);
      wait_step(d, g, t3);
      check("t4_grow3", 32'(g), 32'd1);
      check("t4_period12b", 32'(t3 - t2), 32'd13);
      wait_step(d, g, t1);
      check("t4_grow4", 32'(g), 32'd1);
      wait_step(d, g, t1);
      check("t4_grow_done", 32'(g), 32'd0);
      food_burst(8);
      check("t4_level_sat", 32'(speed_level), 32'd3);
      wait_step(d, g, t1);
      wait_step(d, g, t2);
      check("t4_period8", 32'(t2 - t1), 32'd9);

      // Death mid-request: request withdrawn, state wiped, late ack ignored
      down = 1; cycle();
      game_state = 2'd1; cycle();
      check("t5_req_drop", 32'(step_req), 32'd0);
      check("t5_dir", 32'(dir), 32'd3);
      check("t5_level", 32'(speed_level), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step_ack = 1; cycle();
      end
      check("t5_ack_ignored", 32'(step_req), 32'd0);

      // Reversal and duplicate keys are dropped; queue was cleared by death
      game_state = 2'd0; cycle();
      left = 1;  cycle();
      right = 1; cycle();
      wait_step(d, g, t1);
      check("t3_dropped", 32'(d), 32'd3);
      up = 1; cycle();
      wait_step(d, g, t1);
      check("t3_turn_up", 32'(d), 32'd0);

      // Random play checked cycle by cycle against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            case ($urandom_range(0, 9))
               6, 7:    game_state = 2'd2;
               8:       game_state = 2'd1;
               9:       game_state = 2'd3;
               default: game_state = 2'd0;
            endcase
         end
         up         = ($urandom_range(0, 9) == 0);
         down       = ($urandom_range(0, 9) == 0);
         left       = ($urandom_range(0, 9) == 0);
         right      = ($urandom_range(0, 9) == 0);
         food_eaten = ($urandom_range(0, 14) == 0);
         step_ack   = step_req ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
         cycle();
      end

      // Asynchronous reset in the middle of a countdown
      game_state = 2'd0;
      step_ack = step_req; cycle();
      food_burst(4);
      repeat (3) cycle();
      lvl_before = speed_level;
      check("t6_level_nonzero", 32'(lvl_before != 3'd0), 32'd1);
      #2;
      rst = 0;
      #1;
      model_reset();
      check("t6_async_req", 32'(step_req), 32'd0);
      check("t6_async_dir", 32'(dir), 32'd3);
      check("t6_async_grow", 32'(grow), 32'd0);
      check("t6_async_level", 32'(speed_level), 32'd0);
      @(posedge clk);
      #1;
      check("t6_held_level", 32'(speed_level), 32'd0);
      @(negedge clk);
      rst = 1;
      t0 = cyc;
      wait_step(d, g, t1);
      check("t6_recover_latency", 32'(t1 - t0), 32'd21);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
